serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder_cell.sv | 22 ++
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//   state_e       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand / sum width in bits
// Configuration macro used by this slice: SERIAL_ADDER_SUB_EN
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
// One-bit full adder used as the per-bit datapath of serial_adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit  (a ^ b ^ cin)
//   cout  : carry out (majority of a, b, cin)
// Configuration macro of the enclosing slice: SERIAL_ADDER_SUB_EN (unused here)
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: operands are captured on an accepted start, processed one
// bit per clock (LSB first) through a single full_adder_cell, and the result
// is published on s/c together with a one-cycle done pulse.
// Parameters:
//   WIDTH  : operand and sum width, 1..64
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an addition (only honoured in IDLE)
//   a, b   : operands, captured on the accepted start edge
//   sub    : subtract mode, captured with a/b (only with SERIAL_ADDER_SUB_EN)
//   busy   : high while the serial operation is running
//   done   : one-cycle pulse when s/c carry a new result
//   s      : registered sum (wraps modulo 2^WIDTH)
//   c      : registered carry-out (NOT-borrow when subtracting)
// Configuration macro: SERIAL_ADDER_SUB_EN enables the sub port and
// subtraction; without it the block always adds.
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic             subMode;
  logic             sumBit_d;
  logic             carry_d;
  logic [WIDTH-1:0] shiftA_d;

`ifdef SERIAL_ADDER_SUB_EN
  assign subMode = sub;
`else
  assign subMode = 1'b0;
`endif

  full_adder_cell uCell (
    .a    (shiftA_q[0]),
    .b    (shiftB_q[0]),
    .cin  (carry_q),
    .s    (sumBit_d),
    .cout (carry_d)
  );

  // The A register doubles as the sum accumulator: each sum bit enters at the
  // MSB while A drains from the LSB, so after WIDTH shifts it holds the sum.
  if (WIDTH == 1) begin : gNarrow
    assign shiftA_d = sumBit_d;
  end else begin : gWide
    assign shiftA_d = {sumBit_d, shiftA_q[WIDTH-1:1]};
  end

  // B is stored already inverted in subtract mode, with the carry seeded to 1,
  // so that a + ~b + 1 yields a - b and the final carry is NOT-borrow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shiftA_q <= '0;
      shiftB_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      c_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shiftA_q <= a;
            shiftB_q <= subMode ? ~b : b;
            carry_q  <= subMode;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          shiftA_q <= shiftA_d;
          shiftB_q <= shiftB_q >> 1;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            s_q     <= shiftA_d;
            c_q     <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder: an 8-bit instance exercises addition,
// start-ignored-while-busy, operand changes after start, mid-run reset and
// (with SERIAL_ADDER_SUB_EN) subtraction; a 1-bit instance checks the
// registered half-adder behaviour. Inputs are driven and outputs sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       c;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       c1;

`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c)
  );

  serial_adder #(.WIDTH(1)) dutNarrow (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .s     (s1),
    .c     (c1)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation on the 8-bit instance. Caller must be at a falling
  // edge. Operands are scrambled right after the start edge; with holdStart
  // start stays high through RUN. Returns edges from start to done and the
  // number of sampled cycles with busy high (-1 latency on timeout).
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic subIn, input bit holdStart,
                               output int lat, output int busyCnt);
    a     = aIn;
    b     = bIn;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = subIn;
`endif
    start = 1'b1;
    @(posedge clk);
    lat     = -1;
    busyCnt = 0;
    for (int n = 0; n < 30 && lat < 0; n++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) lat = n;
      a = ~aIn;
      b = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = ~subIn;
`endif
      start = (holdStart && lat < 0) ? 1'b1 : 1'b0;
    end
  endtask

  // Full add-mode check: result, carry, latency, busy duration, hold.
  task automatic runAdd(input string tag, input logic [7:0] aIn, input logic [7:0] bIn,
                        input bit holdStart, input logic [7:0] expS, input logic expC);
    int lat, busyCnt;
    applyStimulus(aIn, bIn, 1'b0, holdStart, lat, busyCnt);
    checkOutput({tag, ".lat"}, 64'(lat), 64'd8);
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'd8);
    checkOutput({tag, ".s"}, 64'(s), 64'(expS));
    checkOutput({tag, ".c"}, 64'(c), 64'(expC));
    repeat (3) @(negedge clk);
    checkOutput({tag, ".idleBusy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".holdS"}, {55'd0, done, s}, {56'd0, expS});
  endtask

  initial begin
    int lat, busyCnt, doneSeen;
    logic [1:0] narrowExp [4];

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = 1'b0;
    sub1   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset", {60'd0, busy, done, c, (s != 8'd0)}, 64'd0);
    checkOutput("resetNarrow", {60'd0, busy1, done1, c1, s1}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runAdd("add5A3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    runAdd("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runAdd("addFFFF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    runAdd("hold8080", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1);
    runAdd("add1234", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Reset during the fourth RUN cycle must abort without a done pulse.
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midReset.state", {60'd0, busy, done, c, (s != 8'd0)}, 64'd0);
    rst_n = 1'b1;
    runAdd("afterReset0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // No stray done pulse may appear while idle.
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("idleNoDone", 64'(doneSeen), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b1, 1'b0, lat, busyCnt);
    checkOutput("sub1001.lat", 64'(lat), 64'd8);
    checkOutput("sub1001.s", 64'(s), 64'h0F);
    checkOutput("sub1001.c", 64'(c), 64'd1);
    applyStimulus(8'h01, 8'h02, 1'b1, 1'b0, lat, busyCnt);
    checkOutput("sub0102.s", 64'(s), 64'hFF);
    checkOutput("sub0102.c", 64'(c), 64'd0);
    applyStimulus(8'h05, 8'h05, 1'b1, 1'b0, lat, busyCnt);
    checkOutput("sub0505.s", 64'(s), 64'h00);
    checkOutput("sub0505.c", 64'(c), 64'd1);
    sub = 1'b0;
    @(negedge clk);
`endif

    // 1-bit instance behaves as a registered half adder: {c, s} per a/b.
    narrowExp[0] = 2'b00;
    narrowExp[1] = 2'b01;
    narrowExp[2] = 2'b01;
    narrowExp[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      a1 = 1'(k >> 1);
      b1 = 1'(k);
      start1 = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int n = 0; n < 10 && lat < 0; n++) begin
        @(negedge clk);
        start1 = 1'b0;
        a1 = ~a1;
        if (done1) lat = n;
      end
      checkOutput($sformatf("narrow%0d.lat", k), 64'(lat), 64'd1);
      checkOutput($sformatf("narrow%0d.sc", k), {62'd0, c1, s1}, {62'd0, narrowExp[k]});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
